sample_slot_sched: RTL

Round-robin slot scheduler that shares the 16-bit magnitude + sign sample path of the ANS-PWM pipeline between NCH sample sources. The PWM consumes one sample per PERIOD clocks. At each slot boundary the scheduler grants one requester, captures its sample and holds it on the datapath input for the full slot. The delay stages downstream are fed directly from its outputs. On disable it flushes the 3-stage delay line with zeros before reporting idle.

---
 rtl/anspwm_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/sample_slot_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/anspwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | anspwm_pkg                                                           |
// | Shared widths, constants and state encoding for the ANS-PWM blocks.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package anspwm_pkg;

   localparam int SAMPLE_W     = 16;
   // Matches the depth of the downstream delay line so a flush clears it fully.
   localparam int DRAIN_CYCLES = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational rotate-priority arbiter; search starts after `last`.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]         req,
   input  logic [$clog2(NCH)-1:0] last,
   input  logic                   en,
   output logic [NCH-1:0]         grant,
   output logic [$clog2(NCH)-1:0] grant_idx,
   output logic                   any
);

   localparam int IDX_W = $clog2(NCH);

   logic [IDX_W-1:0] w_idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      w_idx     = '0;
      for (int i = 1; i <= NCH; i++) begin
         w_idx = IDX_W'((int'(last) + i) % NCH);
         if (en && !any && req[w_idx]) begin
            any          = 1'b1;
            grant[w_idx] = 1'b1;
            grant_idx    = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sample_slot_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample_slot_sched                                                    |
// | Round-robin slot scheduler feeding one sample per PERIOD to the PWM. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sample_slot_sched
   import anspwm_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int PERIOD = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [NCH-1:0]          req_valid,
   input  logic [NCH*SAMPLE_W-1:0] req_val,
   input  logic [NCH-1:0]          req_sign,
   output logic [NCH-1:0]          req_ack,
   output logic [SAMPLE_W-1:0]     val_out,
   output logic                    sign_out,
   output logic                    vld_out,
   output logic [2:0]              ch_out,
   output logic                    busy,
   output logic [15:0]             underrun_cnt
);

   localparam int IDX_W = $clog2(NCH);
   localparam int CNT_W = $clog2(PERIOD);

   sched_state_t          r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_last;
   logic [1:0]            r_drain;
   logic [SAMPLE_W-1:0]   r_val;
   logic                  r_sign;
   logic                  r_vld;
   logic [2:0]            r_ch;
   logic [15:0]           r_underrun_cnt;

   logic                  w_tick;
   logic                  w_arb_en;
   logic [NCH-1:0]        w_grant;
   logic [IDX_W-1:0]      w_grant_idx;
   logic                  w_any;

   assign w_tick   = (r_state == RUN) && (r_cnt == '0);
   // A disabling tick closes the run without granting anyone.
   assign w_arb_en = w_tick && enable;

   rr_arbiter #(
      .NCH (NCH)
   ) u_arb (
      .req       (req_valid),
      .last      (r_last),
      .en        (w_arb_en),
      .grant     (w_grant),
      .grant_idx (w_grant_idx),
      .any       (w_any)
   );

   assign req_ack      = w_grant;
   assign val_out      = r_val;
   assign sign_out     = r_sign;
   assign vld_out      = r_vld;
   assign ch_out       = r_ch;
   assign busy         = (r_state != IDLE);
   assign underrun_cnt = r_underrun_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_last         <= IDX_W'(NCH - 1);
         r_drain        <= '0;
         r_val          <= '0;
         r_sign         <= 1'b0;
         r_vld          <= 1'b0;
         r_ch           <= '0;
         r_underrun_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_state <= RUN;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               if (w_tick) begin
                  r_cnt <= CNT_W'(PERIOD - 1);
                  if (!enable) begin
                     r_state <= DRAIN;
                     r_drain <= '0;
                     r_val   <= '0;
                     r_sign  <= 1'b0;
                     r_vld   <= 1'b0;
                     r_ch    <= '0;
                  end else if (w_any) begin
                     r_val  <= req_val[int'(w_grant_idx)*SAMPLE_W +: SAMPLE_W];
                     r_sign <= req_sign[w_grant_idx];
                     r_vld  <= 1'b1;
                     r_ch   <= 3'(w_grant_idx);
                     r_last <= w_grant_idx;
                  end else begin
                     r_val  <= '0;
                     r_sign <= 1'b0;
                     r_vld  <= 1'b0;
                     r_ch   <= '0;
                     if (r_underrun_cnt != 16'hFFFF)
                        r_underrun_cnt <= r_underrun_cnt + 16'd1;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            DRAIN: begin
               r_val  <= '0;
               r_sign <= 1'b0;
               r_vld  <= 1'b0;
               r_ch   <= '0;
               if (r_drain == 2'(DRAIN_CYCLES - 1))
                  r_state <= IDLE;
               else
                  r_drain <= r_drain + 2'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
